// File: rtl/nmr_bstrm_pkg.sv
// Shared definitions for the bitstream command word: field positions, the
// recorder state encoding and the word packer used by encoder and decoder.
package nmr_bstrm_pkg;

  localparam int WORD_W   = 32;
  localparam int POL_BIT  = 31;
  localparam int END_BIT  = 30;
  localparam int LSTA_BIT = 29;
  localparam int LSTO_BIT = 28;
  localparam int MUX_HI   = 27;
  localparam int MUX_LO   = 24;
  localparam int DATA_HI  = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_FLUSH,
    ST_TERM
  } state_e;

  // Assemble one command word; loop markers are never produced by the recorder.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic                    pol,
    input logic                    seq_end,
    input logic [MUX_HI-MUX_LO:0]  mux,
    input logic [DATA_HI:0]        len
  );
    logic [WORD_W-1:0] w;
    w                = '0;
    w[POL_BIT]       = pol;
    w[END_BIT]       = seq_end;
    w[LSTA_BIT]      = 1'b0;
    w[LSTO_BIT]      = 1'b0;
    w[MUX_HI:MUX_LO] = mux;
    w[DATA_HI:0]     = len;
    return w;
  endfunction

endpackage

// File: rtl/nmr_sync2.sv
// Two-flop synchronizer for a single asynchronous line.
module nmr_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nmr_bstrm_simp_rec.sv
// Bitstream recorder: run-length encodes a synchronized digital line into
// sequential command words on a RAM write port, ending with a terminator.
module nmr_bstrm_simp_rec
  import nmr_bstrm_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH  = 32,
  parameter int DATA_WIDTH      = 24,
  parameter int LEN_OFFSET      = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  input  logic                       STOP,
  input  logic                       IN,
  input  logic [3:0]                 MUX_SEL,
  output logic                       DONE,
  output logic                       BUSY,
  output logic                       OVERFLOW,
  output logic [SRAM_ADDR_WIDTH:0]   WORD_CNT,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [SRAM_DAT_WIDTH-1:0]  SRAM_WR_DAT,
  output logic                       SRAM_WE
);

  localparam int LEN_W = DATA_HI + 1;
  // Highest address a run word may use; the one above it holds the terminator.
  localparam logic [SRAM_ADDR_WIDTH-1:0] LAST_RUN_ADDR =
    {{(SRAM_ADDR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};

  state_e                     state_q;
  logic                       lvl_q;
  logic [DATA_WIDTH-1:0]      cnt_q;
  logic [SRAM_ADDR_WIDTH-1:0] ptr_q;
  logic                       we_q;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [SRAM_DAT_WIDTH-1:0]  dat_q;
  logic                       done_q;
  logic                       busy_q;
  logic                       ovf_q;
  logic [SRAM_ADDR_WIDTH:0]   wcnt_q;

  logic                       in_s;
  logic                       take_d;
  logic [SRAM_DAT_WIDTH-1:0]  run_word_d;
  logic [SRAM_DAT_WIDTH-1:0]  term_word_d;
  logic [SRAM_ADDR_WIDTH:0]   wcnt_d;

  // Measured run minus playback overhead, never below one clock.
  function automatic logic [DATA_WIDTH-1:0] run_len(input logic [DATA_WIDTH-1:0] c);
    if (int'({1'b0, c}) > LEN_OFFSET) begin
      return c - DATA_WIDTH'(LEN_OFFSET);
    end
    return DATA_WIDTH'(1);
  endfunction

  nmr_sync2 u_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (IN),
    .q_o    (in_s)
  );

  // Word images and the "close the current run" decision for this cycle.
  always_comb begin
    take_d      = (in_s != lvl_q) || (cnt_q == CNT_MAX);
    run_word_d  = SRAM_DAT_WIDTH'(pack_word(lvl_q, 1'b0, MUX_SEL, LEN_W'(run_len(cnt_q))));
    term_word_d = SRAM_DAT_WIDTH'(pack_word(lvl_q, 1'b1, 4'd0, '0));
    wcnt_d      = {1'b0, ptr_q} + (SRAM_ADDR_WIDTH+1)'(1);
  end

  // Recorder FSM with registered write port and status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      done_q  <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_ARM;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        ST_ARM: begin
          lvl_q   <= in_s;
          cnt_q   <= DATA_WIDTH'(1);
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (STOP) begin
            // The sample seen with STOP is dropped, even if it is an edge.
            state_q <= ST_FLUSH;
          end else if (take_d) begin
            // An edge or a saturated counter closes the run; the current
            // sample opens the next one (same polarity when saturating).
            we_q   <= 1'b1;
            addr_q <= ptr_q;
            dat_q  <= run_word_d;
            ptr_q  <= ptr_q + SRAM_ADDR_WIDTH'(1);
            lvl_q  <= in_s;
            cnt_q  <= DATA_WIDTH'(1);
            if (ptr_q == LAST_RUN_ADDR) begin
              ovf_q   <= 1'b1;
              state_q <= ST_TERM;
            end
          end else begin
            cnt_q <= cnt_q + DATA_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          dat_q   <= run_word_d;
          ptr_q   <= ptr_q + SRAM_ADDR_WIDTH'(1);
          state_q <= ST_TERM;
        end
        ST_TERM: begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          dat_q   <= term_word_d;
          wcnt_q  <= wcnt_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DONE        = done_q;
  assign BUSY        = busy_q;
  assign OVERFLOW    = ovf_q;
  assign WORD_CNT    = wcnt_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_WR_DAT = dat_q;
  assign SRAM_WE     = we_q;

endmodule

// File: tb/tb_nmr_bstrm_simp_rec.sv
// Bench for the bitstream recorder: four builds (default, offset 2, 4-bit
// length, 3-bit address) driven with directed sample sequences.
module tb_nmr_bstrm_simp_rec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v [4];
  logic       start_v [4];
  logic       stop_v [4];
  logic       in_v [4];
  logic [3:0] mux_v [4];

  logic done0, busy0, ovf0, we0; logic [8:0] wc0; logic [7:0] ad0; logic [31:0] dt0;
  logic done1, busy1, ovf1, we1; logic [8:0] wc1; logic [7:0] ad1; logic [31:0] dt1;
  logic done2, busy2, ovf2, we2; logic [8:0] wc2; logic [7:0] ad2; logic [31:0] dt2;
  logic done3, busy3, ovf3, we3; logic [3:0] wc3; logic [2:0] ad3; logic [31:0] dt3;

  nmr_bstrm_simp_rec u_dut0 (
    .CLK(clk), .RST_N(rst_v[0]), .START(start_v[0]), .STOP(stop_v[0]), .IN(in_v[0]),
    .MUX_SEL(mux_v[0]), .DONE(done0), .BUSY(busy0), .OVERFLOW(ovf0), .WORD_CNT(wc0),
    .SRAM_ADDR(ad0), .SRAM_WR_DAT(dt0), .SRAM_WE(we0));

  nmr_bstrm_simp_rec #(.LEN_OFFSET(2)) u_dut1 (
    .CLK(clk), .RST_N(rst_v[1]), .START(start_v[1]), .STOP(stop_v[1]), .IN(in_v[1]),
    .MUX_SEL(mux_v[1]), .DONE(done1), .BUSY(busy1), .OVERFLOW(ovf1), .WORD_CNT(wc1),
    .SRAM_ADDR(ad1), .SRAM_WR_DAT(dt1), .SRAM_WE(we1));

  nmr_bstrm_simp_rec #(.DATA_WIDTH(4)) u_dut2 (
    .CLK(clk), .RST_N(rst_v[2]), .START(start_v[2]), .STOP(stop_v[2]), .IN(in_v[2]),
    .MUX_SEL(mux_v[2]), .DONE(done2), .BUSY(busy2), .OVERFLOW(ovf2), .WORD_CNT(wc2),
    .SRAM_ADDR(ad2), .SRAM_WR_DAT(dt2), .SRAM_WE(we2));

  nmr_bstrm_simp_rec #(.SRAM_ADDR_WIDTH(3)) u_dut3 (
    .CLK(clk), .RST_N(rst_v[3]), .START(start_v[3]), .STOP(stop_v[3]), .IN(in_v[3]),
    .MUX_SEL(mux_v[3]), .DONE(done3), .BUSY(busy3), .OVERFLOW(ovf3), .WORD_CNT(wc3),
    .SRAM_ADDR(ad3), .SRAM_WR_DAT(dt3), .SRAM_WE(we3));

  logic        we_n [4];
  logic        done_n [4];
  logic        busy_n [4];
  logic        ovf_n [4];
  int          addr_n [4];
  int          wc_n [4];
  logic [31:0] dat_n [4];

  assign we_n[0] = we0;   assign we_n[1] = we1;   assign we_n[2] = we2;   assign we_n[3] = we3;
  assign done_n[0] = done0; assign done_n[1] = done1; assign done_n[2] = done2; assign done_n[3] = done3;
  assign busy_n[0] = busy0; assign busy_n[1] = busy1; assign busy_n[2] = busy2; assign busy_n[3] = busy3;
  assign ovf_n[0] = ovf0; assign ovf_n[1] = ovf1; assign ovf_n[2] = ovf2; assign ovf_n[3] = ovf3;
  assign addr_n[0] = int'(ad0); assign addr_n[1] = int'(ad1);
  assign addr_n[2] = int'(ad2); assign addr_n[3] = int'(ad3);
  assign wc_n[0] = int'(wc0); assign wc_n[1] = int'(wc1);
  assign wc_n[2] = int'(wc2); assign wc_n[3] = int'(wc3);
  assign dat_n[0] = dt0; assign dat_n[1] = dt1; assign dat_n[2] = dt2; assign dat_n[3] = dt3;

  int          tests = 0;
  int          fails = 0;
  int          cur = 0;
  bit          active = 1'b0;
  int          widx = 0;
  logic [31:0] exp_q [$];
  int          exp_wc = 0;
  bit          exp_ovf = 1'b0;
  bit          seq [$];
  logic [31:0] ram [256];

  task automatic chk(input string nm, input longint act, input longint exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic add(input bit v, input int cnt);
    repeat (cnt) seq.push_back(v);
  endtask

  // Reference: split the counted samples into level runs, cut runs longer
  // than the counter range, truncate to the RAM, then append the terminator.
  task automatic build_model(input int n, input int off, input int dw, input int aw,
                             input logic [3:0] mux);
    bit clvl [$];
    int clen [$];
    int j, run, mx, slots, nw, lv_len;
    bit lv, tp;
    mx = (1 << dw) - 1;
    j = 0;
    while (j < n) begin
      lv = seq[j];
      run = 0;
      while (j < n && seq[j] == lv) begin
        run++;
        j++;
      end
      while (run > mx) begin
        clvl.push_back(lv);
        clen.push_back(mx);
        run -= mx;
      end
      clvl.push_back(lv);
      clen.push_back(run);
    end
    slots = (1 << aw) - 1;
    exp_q.delete();
    if (clen.size() - 1 >= slots) begin
      exp_ovf = 1'b1;
      nw = slots;
      tp = clvl[slots];
    end else begin
      exp_ovf = 1'b0;
      nw = clen.size();
      tp = clvl[nw-1];
    end
    for (int i = 0; i < nw; i++) begin
      lv_len = clen[i] - off;
      if (lv_len < 1) lv_len = 1;
      exp_q.push_back({clvl[i], 3'b000, mux, 24'(lv_len)});
    end
    exp_q.push_back({tp, 1'b1, 30'd0});
    exp_wc = nw + 1;
  endtask

  // Per-cycle comparison of the active instance's write port against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (active) begin
        chk("busy_vs_done", busy_n[cur], !done_n[cur]);
        if (we_n[cur]) begin
          if (widx < exp_q.size()) begin
            chk("wr_addr", addr_n[cur], widx);
            chk("wr_data", dat_n[cur], exp_q[widx]);
          end else begin
            tests++;
            fails++;
            $display("FAIL extra_write: write at addr %0d, expected only %0d words",
                     addr_n[cur], exp_q.size());
          end
          ram[addr_n[cur] & 255] = dat_n[cur];
          widx++;
        end
      end
    end
  end

  // seq holds the counted samples plus one trailing sample seen with STOP.
  task automatic record(input int inst, input int n, input bit do_stop,
                        input logic [3:0] mux, input int busy_k, input int rst_k);
    int total;
    bit got;
    cur = inst;
    widx = 0;
    foreach (ram[i]) ram[i] = '0;
    mux_v[inst] = mux;
    total = seq.size() + 2;
    active = 1'b1;
    for (int k = 0; k < total; k++) begin
      @(posedge clk);
      #1;
      in_v[inst]    = seq[(k < seq.size()) ? k : seq.size() - 1];
      start_v[inst] = (k == 1) || (busy_k > 0 && (k == busy_k || k == busy_k + 2));
      stop_v[inst]  = do_stop && (k == n + 2);
      if (k == rst_k) begin
        #3;
        chk("we_before_reset", we_n[inst], 1);
        active = 1'b0;
        rst_v[inst] = 1'b0;
        #1;
        chk("rst_we", we_n[inst], 0);
        chk("rst_done", done_n[inst], 1);
        chk("rst_busy", busy_n[inst], 0);
        chk("rst_ovf", ovf_n[inst], 0);
        chk("rst_wc", wc_n[inst], 0);
        chk("rst_addr", addr_n[inst], 0);
        @(posedge clk);
        #2;
        rst_v[inst] = 1'b1;
        start_v[inst] = 1'b0;
        return;
      end
    end
    start_v[inst] = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 80 && !got; w++) begin
      @(negedge clk);
      got = done_n[inst];
    end
    chk("done_reached", got, 1);
    repeat (3) @(negedge clk);
    active = 1'b0;
    stop_v[inst] = 1'b0;
    chk("word_count", wc_n[inst], exp_wc);
    chk("overflow", ovf_n[inst], exp_ovf);
    chk("num_writes", widx, exp_q.size());
    chk("busy_idle", busy_n[inst], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0; start_v[i] = 1'b0; stop_v[i] = 1'b0; in_v[i] = 1'b0; mux_v[i] = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_done", done_n[i], 1);
      chk("reset_busy", busy_n[i], 0);
      chk("reset_ovf", ovf_n[i], 0);
      chk("reset_wc", wc_n[i], 0);
      chk("reset_we", we_n[i], 0);
      chk("reset_addr", addr_n[i], 0);
    end
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;

    // Basic pattern: low 10, high 5, low 3.
    seq.delete(); add(0, 10); add(1, 5); add(0, 3); add(0, 1);
    build_model(18, 0, 24, 8, 4'd0);
    record(0, 18, 1'b1, 4'd0, -1, -1);
    chk("basic_w0", ram[0], 32'h0000000A);
    chk("basic_w1", ram[1], 32'h80000005);
    chk("basic_w2", ram[2], 32'h00000003);
    chk("basic_term", ram[3], 32'h40000000);
    chk("basic_wc", wc0, 4);

    // MUX_SEL field and length offset with the floor at 1.
    seq.delete(); add(1, 7); add(0, 1); add(0, 1);
    build_model(8, 2, 24, 8, 4'hA);
    record(1, 8, 1'b1, 4'hA, -1, -1);
    chk("mux_w0", ram[0], 32'h8A000005);
    chk("mux_w1", ram[1], 32'h0A000001);
    chk("mux_term", ram[2], 32'h40000000);

    // Saturation with a 4-bit length field.
    seq.delete(); add(1, 20); add(1, 1);
    build_model(20, 0, 4, 8, 4'd0);
    record(2, 20, 1'b1, 4'd0, -1, -1);
    chk("sat_w0", ram[0], 32'h8000000F);
    chk("sat_w1", ram[1], 32'h80000005);
    chk("sat_term", ram[2], 32'hC0000000);

    // Overflow with an 8-word RAM, toggling every 2 clocks, no STOP.
    seq.delete();
    for (int i = 0; i < 10; i++) begin add(0, 2); add(1, 2); end
    build_model(40, 0, 24, 3, 4'd0);
    record(3, 40, 1'b0, 4'd0, -1, -1);
    chk("ovf_w1", ram[1], 32'h80000002);
    chk("ovf_w6", ram[6], 32'h00000002);
    chk("ovf_term", ram[7], 32'hC0000000);
    chk("ovf_flag", ovf3, 1);
    chk("ovf_wc", wc3, 8);

    // A new START clears OVERFLOW.
    seq.delete(); add(1, 3); add(1, 1);
    build_model(3, 0, 24, 3, 4'd0);
    record(3, 3, 1'b1, 4'd0, -1, -1);
    chk("reovf_w0", ram[0], 32'h80000003);
    chk("reovf_flag", ovf3, 0);

    // STOP coincident with an edge, plus START pulses while busy.
    seq.delete(); add(1, 4); add(0, 3); add(1, 1);
    build_model(7, 0, 24, 8, 4'h5);
    record(0, 7, 1'b1, 4'h5, 6, -1);
    chk("stopedge_w0", ram[0], 32'h85000004);
    chk("stopedge_w1", ram[1], 32'h05000003);
    chk("stopedge_term", ram[2], 32'h40000000);

    // Reset mid-run on a stream of 1-cycle glitches.
    seq.delete();
    for (int i = 0; i < 10; i++) begin add(0, 1); add(1, 1); end
    build_model(20, 0, 24, 8, 4'd0);
    record(0, 20, 1'b0, 4'd0, -1, 8);
    chk("glitch_w0", ram[0], 32'h00000001);
    chk("glitch_w1", ram[1], 32'h80000001);

    // Fresh recording after reset starts at address 0.
    seq.delete(); add(1, 2); add(0, 3); add(0, 1);
    build_model(5, 0, 24, 8, 4'd0);
    record(0, 5, 1'b1, 4'd0, -1, -1);
    chk("after_rst_w0", ram[0], 32'h80000002);
    chk("after_rst_w1", ram[1], 32'h00000003);
    chk("after_rst_wc", wc0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
